// File: rtl/ux607_qspi_xip_pfbuf_pkg.sv
// Shared definitions for the XIP read-prefetch buffer: FSM state encoding
// and the word stride used to form the next sequential fetch address.

`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

package ux607_qspi_xip_pfbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HIT_RSP = 3'd1,
        ST_FWD_CMD = 3'd2,
        ST_FWD_RSP = 3'd3,
        ST_UP_RSP  = 3'd4,
        ST_PF_CMD  = 3'd5,
        ST_PF_RSP  = 3'd6
    } pf_state_e;

    localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/ux607_qspi_xip_pfbuf.sv
// XIP read-prefetch buffer sitting in front of the QSPI flash ICB slave.
// Read misses are forwarded, then the next sequential word is fetched into
// a one-word buffer so straight-line fetch hits without a flash round trip.
// Writes are forwarded unchanged and invalidate the buffer.

`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

module ux607_qspi_xip_pfbuf
    import ux607_qspi_xip_pfbuf_pkg::*;
#(
    parameter bit          PREFETCH_EN = 1'b1,
    parameter int unsigned WIN_W       = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,

    input  logic                        s_icb_cmd_valid,
    output logic                        s_icb_cmd_ready,
    input  logic [`UX607_PA_SIZE-1:0]   s_icb_cmd_addr,
    input  logic                        s_icb_cmd_read,
    input  logic [31:0]                 s_icb_cmd_wdata,
    output logic                        s_icb_rsp_valid,
    input  logic                        s_icb_rsp_ready,
    output logic [31:0]                 s_icb_rsp_rdata,

    output logic                        m_icb_cmd_valid,
    input  logic                        m_icb_cmd_ready,
    output logic [`UX607_PA_SIZE-1:0]   m_icb_cmd_addr,
    output logic                        m_icb_cmd_read,
    output logic [31:0]                 m_icb_cmd_wdata,
    input  logic                        m_icb_rsp_valid,
    output logic                        m_icb_rsp_ready,
    input  logic [31:0]                 m_icb_rsp_rdata
);

    localparam int unsigned PA = `UX607_PA_SIZE;

    // Bits inside the flash window wrap on increment; bits above it are kept.
    localparam logic [PA-1:0] WIN_MASK =
        (WIN_W >= PA) ? {PA{1'b1}} : ((PA'(1) << WIN_W) - PA'(1));

    function automatic logic [PA-1:0] next_word_addr(input logic [PA-1:0] a);
        next_word_addr = (a & ~WIN_MASK) | ((a + PA'(WORD_STRIDE)) & WIN_MASK);
    endfunction

    pf_state_e       state_q,     state_d;
    logic [PA-1:0]   cmd_addr_q,  cmd_addr_d;
    logic            cmd_read_q,  cmd_read_d;
    logic [31:0]     cmd_wdata_q, cmd_wdata_d;
    logic [31:0]     rsp_data_q,  rsp_data_d;
    logic            buf_vld_q,   buf_vld_d;
    logic [PA-1:2]   buf_addr_q,  buf_addr_d;
    logic [31:0]     buf_data_q,  buf_data_d;
    logic [PA-1:0]   pf_addr_q,   pf_addr_d;
    logic            drop_q,      drop_d;

    // Next-state, command capture, buffer update and flush handling.
    always_comb begin
        state_d     = state_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_read_d  = cmd_read_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_data_d  = rsp_data_q;
        buf_vld_d   = buf_vld_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        pf_addr_d   = pf_addr_q;
        drop_d      = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (s_icb_cmd_valid) begin
                    cmd_addr_d  = s_icb_cmd_addr;
                    cmd_read_d  = s_icb_cmd_read;
                    cmd_wdata_d = s_icb_cmd_wdata;
                    if (s_icb_cmd_read && buf_vld_q && !flush &&
                        (s_icb_cmd_addr[PA-1:2] == buf_addr_q)) begin
                        rsp_data_d = buf_data_q;
                        state_d    = ST_HIT_RSP;
                    end else begin
                        state_d = ST_FWD_CMD;
                        if (!s_icb_cmd_read) begin
                            buf_vld_d = 1'b0;
                        end
                    end
                end
            end
            ST_HIT_RSP: begin
                if (s_icb_rsp_ready) begin
                    if (PREFETCH_EN) begin
                        pf_addr_d = next_word_addr(cmd_addr_q);
                        drop_d    = 1'b0;
                        state_d   = ST_PF_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FWD_CMD: begin
                if (m_icb_cmd_ready) begin
                    state_d = ST_FWD_RSP;
                end
            end
            ST_FWD_RSP: begin
                if (m_icb_rsp_valid) begin
                    rsp_data_d = cmd_read_q ? m_icb_rsp_rdata : 32'h0;
                    state_d    = ST_UP_RSP;
                end
            end
            ST_UP_RSP: begin
                if (s_icb_rsp_ready) begin
                    if (PREFETCH_EN && cmd_read_q) begin
                        pf_addr_d = next_word_addr(cmd_addr_q);
                        drop_d    = 1'b0;
                        state_d   = ST_PF_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PF_CMD: begin
                if (m_icb_cmd_ready) begin
                    state_d = ST_PF_RSP;
                end
            end
            ST_PF_RSP: begin
                if (m_icb_rsp_valid) begin
                    if (!drop_q && !flush) begin
                        buf_data_d = m_icb_rsp_rdata;
                        buf_addr_d = pf_addr_q[PA-1:2];
                        buf_vld_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush during an in-flight prefetch lets the transaction finish
        // but marks its data as stale so it never lands in the buffer.
        if (flush) begin
            buf_vld_d = 1'b0;
            if ((state_q == ST_PF_CMD) || (state_q == ST_PF_RSP)) begin
                drop_d = 1'b1;
            end
        end
    end

    // State and buffer registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_addr_q  <= '0;
            cmd_read_q  <= 1'b0;
            cmd_wdata_q <= '0;
            rsp_data_q  <= '0;
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            pf_addr_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_read_q  <= cmd_read_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_data_q  <= rsp_data_d;
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            pf_addr_q   <= pf_addr_d;
            drop_q      <= drop_d;
        end
    end

    // Handshakes decode from state alone; payloads come from registers, so
    // nothing upstream reaches the downstream port combinationally.
    assign s_icb_cmd_ready = (state_q == ST_IDLE);
    assign s_icb_rsp_valid = (state_q == ST_HIT_RSP) || (state_q == ST_UP_RSP);
    assign s_icb_rsp_rdata = rsp_data_q;

    assign m_icb_cmd_valid = (state_q == ST_FWD_CMD) || (state_q == ST_PF_CMD);
    assign m_icb_cmd_addr  = (state_q == ST_PF_CMD) ? pf_addr_q : cmd_addr_q;
    assign m_icb_cmd_read  = (state_q == ST_PF_CMD) ? 1'b1 : cmd_read_q;
    assign m_icb_cmd_wdata = (state_q == ST_PF_CMD) ? 32'h0 : cmd_wdata_q;
    assign m_icb_rsp_ready = (state_q == ST_FWD_RSP) || (state_q == ST_PF_RSP);

endmodule

// File: doc/ux607_qspi_xip_pfbuf.md
# ux607_qspi_xip_pfbuf

XIP read-prefetch buffer placed directly upstream of the single-chip-select QSPI flash peripheral on the ICB bus. Accepts 32-bit ICB requests from the core-side bus and forwards them to the QSPI ICB slave. After each read miss it speculatively fetches the next sequential word and holds it in a one-word buffer, so straight-line instruction fetch from flash hits without a QSPI round trip. Writes are forwarded unchanged and invalidate the buffer.

## Interface
- PREFETCH_EN, 1: 1 enables the next-word prefetch; 0 makes the block a registered pass-through.
- WIN_W, 24: flash window offset width; prefetch address increments wrap within bits [WIN_W-1:0].
- clk  input  1  core clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  single-cycle pulse that invalidates the buffer.
- s_icb_cmd_valid / s_icb_cmd_ready  input / output  1  upstream command handshake.
- s_icb_cmd_addr  input  `UX607_PA_SIZE  byte address, word-aligned.
- s_icb_cmd_read  input  1  1 = read, 0 = write.
- s_icb_cmd_wdata  input  32  write data.
- s_icb_rsp_valid / s_icb_rsp_ready  output / input  1  upstream response handshake.
- s_icb_rsp_rdata  output  32  read data (0 for writes).
- m_icb_cmd_valid / m_icb_cmd_ready  output / input  1  downstream command handshake toward QSPI.
- m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata  output  `UX607_PA_SIZE, 1, 32  downstream command payload.
- m_icb_rsp_valid / m_icb_rsp_ready  input / output  1  downstream response handshake.
- m_icb_rsp_rdata  input  32  downstream read data.

## Operation
- States: IDLE, HIT_RSP, FWD_CMD, FWD_RSP, UP_RSP, PF_CMD, PF_RSP.
- Buffer: buf_vld, buf_addr[`UX607_PA_SIZE-1:2], buf_data[31:0].
- IDLE: s_icb_cmd_ready = 1. On accept:
  - Read with buf_vld and addr[PA-1:2] == buf_addr: go to HIT_RSP.
  - Otherwise: latch the command and go to FWD_CMD.
  - Write: clear buf_vld on accept.
- HIT_RSP: s_icb_rsp_valid = 1 with buf_data. On rsp handshake: if PREFETCH_EN, set pf_addr = hit addr + 4 and go to PF_CMD; else go to IDLE.
- FWD_CMD: m_icb_cmd_valid = 1 with the latched payload. On m_icb_cmd_ready, go to FWD_RSP.
- FWD_RSP: m_icb_rsp_ready = 1. On m_icb_rsp_valid, register rdata and go to UP_RSP.
- UP_RSP: s_icb_rsp_valid = 1 with the registered data. On handshake:
  - Read with PREFETCH_EN: pf_addr = addr + 4, go to PF_CMD.
  - Otherwise: go to IDLE.
- PF_CMD: m_icb_cmd_valid = 1, read, addr = pf_addr. On ready, go to PF_RSP.
- PF_RSP: m_icb_rsp_ready = 1. On valid: buf_data = rdata, buf_addr = pf_addr[PA-1:2], buf_vld = 1, go to IDLE.
- s_icb_cmd_ready is 0 in every state except IDLE; upstream stalls during a prefetch. Only one downstream transaction is outstanding at any time.
- Prefetch address: bits [WIN_W-1:0] = offset + 4 mod 2^WIN_W; upper bits copied. 0x00FFFFFC -> 0x00000000.
- flush: clears buf_vld in any state. In PF_CMD or PF_RSP it also sets a drop flag, so the returning prefetch data is not stored (buf_vld stays 0). The transaction itself still completes.
- flush coincident with a hit lookup in IDLE: the lookup treats the buffer as invalid, so the request misses.

## Timing
- Reset values:
  - All *_valid outputs and m_icb_rsp_ready = 0.
  - s_icb_cmd_ready = 1.
  - rdata, addr and wdata outputs = 0.
  - buf_vld = 0; state = IDLE.
- Hit: command accepted at cycle T, s_icb_rsp_valid at T+1.
- Miss: command accepted at T, m_icb_cmd_valid at T+1. Downstream response at cycle R gives s_icb_rsp_valid at R+1.
- All outputs are registered or decoded from state only; there is no combinational path from s_* to m_*.
- Valid outputs hold with a stable payload until the corresponding ready is high.
- Reset asserted mid-transaction aborts immediately to reset values. The QSPI block shares rst_n.

## Structure
- Shared package/header: state encodings and the constant 4 (word stride). Address width comes from the existing `UX607_PA_SIZE define.
- No sub-module; single FSM plus buffer registers, about 200 lines.
- Instantiated between the bus fabric's QSPI flash port and the QSPI top.

## Test plan
- Cold read 0x20000100 → downstream read 0x20000100, upstream data D0, then prefetch read 0x20000104. A following read of 0x20000104 responds in 1 cycle with no downstream command.
- Write to 0x20000104 after prefetch → write forwarded and buf_vld = 0. Next read of 0x20000104 issues a downstream read.
- Read at offset 0x00FFFFFC → prefetch address 0x20000000 (upper bits kept, offset wrapped).
- flush pulsed during PF_RSP → prefetch data discarded. Read of the prefetched address misses.
- m_icb_cmd_ready held low for 5 cycles and s_icb_rsp_ready low for 3 cycles → valids and payloads stay stable; each transaction occurs exactly once.
- PREFETCH_EN = 0: two sequential reads → two downstream reads, buf_vld always 0.
